// File: rtl/display_scanner.sv
// Four-digit time-multiplexed glyph scanner with frame-aligned double-buffered code updates.
// Optional blinking of masked digits is enabled by defining DISPLAY_SCANNER_BLINK_EN.
module display_scanner #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] codes_in,
  input  logic        load,
  input  logic [3:0]  blink_mask,
  output logic [1:0]  pos,
  output logic [2:0]  num,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [2:0] BlankCode = 3'd4;
  localparam logic [11:0] BlankAll = {4{BlankCode}};

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    pos_q, pos_d;
  logic [3:0]    an_q, an_d;
  logic [2:0]    num_q, num_d;
  logic [11:0]   active_q, active_d;
  logic [11:0]   buf_q, buf_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          boundary;
  logic [2:0]    code_sel;
  logic          blank;

  assign tick     = (presc_q == PW'(CLK_DIV - 1));
  assign boundary = tick && (pos_q == 2'd3);

`ifdef DISPLAY_SCANNER_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-state phase so the first digit of a new blink half-period is already right.
  assign blank = phase_d & blink_mask[pos_d];
`else
  localparam int unsigned UnusedBlinkFrames = BLINK_FRAMES;
  logic unused_blink_mask;

  assign unused_blink_mask = ^blink_mask;
  assign blank             = 1'b0;
`endif

  always_comb begin
    presc_d      = tick ? '0 : presc_q + PW'(1);
    buf_d        = load ? codes_in : buf_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = boundary;

    if (boundary) begin
      // A load landing on the boundary edge goes straight to the active set.
      pending_d = 1'b0;
      if (load) begin
        active_d = codes_in;
      end else if (pending_q) begin
        active_d = buf_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end

    pos_d = tick ? pos_q + 2'd1 : pos_q;
    an_d  = ~(4'b0001 << pos_d);

    code_sel = active_d[2:0];
    unique case (pos_d)
      2'd0: code_sel = active_d[2:0];
      2'd1: code_sel = active_d[5:3];
      2'd2: code_sel = active_d[8:6];
      2'd3: code_sel = active_d[11:9];
      default: code_sel = active_d[2:0];
    endcase

    num_d = num_q;
    if (tick) begin
      num_d = blank ? BlankCode : code_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      pos_q        <= 2'd0;
      an_q         <= 4'b1110;
      num_q        <= BlankCode;
      active_q     <= BlankAll;
      buf_q        <= BlankAll;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pos_q        <= pos_d;
      an_q         <= an_d;
      num_q        <= num_d;
      active_q     <= active_d;
      buf_q        <= buf_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pos        = pos_q;
  assign an         = an_q;
  assign num        = num_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner with CLK_DIV=4 and BLINK_FRAMES=2.
module tb_display_scanner;

  logic        clk;
  logic        rst;
  logic [11:0] codes_in;
  logic        load;
  logic [3:0]  blink_mask;
  logic [1:0]  pos;
  logic [2:0]  num;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int n_cmp;
  int n_bad;

  display_scanner #(
    .CLK_DIV     (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .codes_in  (codes_in),
    .load      (load),
    .blink_mask(blink_mask),
    .pos       (pos),
    .num       (num),
    .an        (an),
    .pending   (pending),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at a falling edge with reset just released; the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    load       = 1'b0;
    codes_in   = 12'h000;
    blink_mask = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    #2;
    n_cmp++; if (pos !== 2'd0) begin n_bad++; $display("FAIL rst_pos got %0d exp 0", pos); end
    n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL rst_an got %b exp 1110", an); end
    n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL rst_num got %0d exp 4", num); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending got %b exp 0", pending); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_fd got %b exp 0", frame_done); end
    // Load mid-frame, then reset asynchronously while pos=1 and the update is pending.
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      if (e == 1) begin codes_in = 12'hFFF; load = 1'b1; end
      if (e == 2) load = 1'b0;
    end
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL pre_rst_pending got %b exp 1", pending); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (pos !== 2'd0) begin n_bad++; $display("FAIL async_pos got %0d exp 0", pos); end
    n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL async_an got %b exp 1110", an); end
    n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL async_num got %0d exp 4", num); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL async_pending got %b exp 0", pending); end
    @(negedge clk);
    rst = 1'b0;
    // The discarded update must never reach the display.
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((e / 4) % 4));
      n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL discard_num e=%0d got %0d exp 4", e, num); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL discard_an e=%0d got %b exp %b", e, an, exp_an); end
    end
  endtask

  task automatic test_scan();
    logic [1:0] exp_pos;
    logic [3:0] exp_an;
    logic       exp_fd;
    do_reset();
    for (int e = 1; e <= 36; e++) begin
      @(negedge clk);
      exp_pos = 2'((e / 4) % 4);
      exp_an  = ~(4'b0001 << exp_pos);
      exp_fd  = (e % 16 == 0);
      n_cmp++; if (pos !== exp_pos) begin n_bad++; $display("FAIL scan_pos e=%0d got %0d exp %0d", e, pos, exp_pos); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL scan_an e=%0d got %b exp %b", e, an, exp_an); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("FAIL scan_fd e=%0d got %b exp %b", e, frame_done, exp_fd); end
      n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL scan_num e=%0d got %0d exp 4", e, num); end
    end
  endtask

  task automatic test_deferred();
    logic [2:0] exp_num;
    logic       exp_pend;
    do_reset();
    for (int e = 1; e <= 31; e++) begin
      @(negedge clk);
      exp_num  = (e < 16) ? 3'd4 : 3'((e / 4) % 4);
      exp_pend = (e >= 6) && (e <= 15);
      n_cmp++; if (num !== exp_num) begin n_bad++; $display("FAIL defer_num e=%0d got %0d exp %0d", e, num, exp_num); end
      n_cmp++; if (pending !== exp_pend) begin n_bad++; $display("FAIL defer_pending e=%0d got %b exp %b", e, pending, exp_pend); end
      if (e == 5) begin codes_in = 12'b011_010_001_000; load = 1'b1; end
      if (e == 6) load = 1'b0;
    end
  endtask

  task automatic test_overwrite();
    logic [2:0] exp_num;
    logic       exp_pend;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      exp_num  = (e < 16) ? 3'd4 : 3'd7;
      exp_pend = (e >= 2) && (e <= 15);
      n_cmp++; if (num !== exp_num) begin n_bad++; $display("FAIL ovr_num e=%0d got %0d exp %0d", e, num, exp_num); end
      n_cmp++; if (pending !== exp_pend) begin n_bad++; $display("FAIL ovr_pending e=%0d got %b exp %b", e, pending, exp_pend); end
      if (e == 1) begin codes_in = 12'b001_001_001_001; load = 1'b1; end
      if (e == 2) load = 1'b0;
      if (e == 9) begin codes_in = 12'hFFF; load = 1'b1; end
      if (e == 10) load = 1'b0;
    end
  endtask

  task automatic test_collision();
    logic [2:0] exp_num;
    logic       exp_pend;
    do_reset();
    // A pending all-3 update is superseded by an all-5 load on the boundary edge (edge 16).
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      exp_num  = (e < 16) ? 3'd4 : 3'd5;
      exp_pend = (e >= 3) && (e <= 15);
      n_cmp++; if (num !== exp_num) begin n_bad++; $display("FAIL coll_num e=%0d got %0d exp %0d", e, num, exp_num); end
      n_cmp++; if (pending !== exp_pend) begin n_bad++; $display("FAIL coll_pending e=%0d got %b exp %b", e, pending, exp_pend); end
      if (e == 16) begin
        n_cmp++; if (pos !== 2'd0) begin n_bad++; $display("FAIL coll_pos got %0d exp 0", pos); end
      end
      if (e == 2) begin codes_in = 12'b011_011_011_011; load = 1'b1; end
      if (e == 3) load = 1'b0;
      if (e == 15) begin codes_in = 12'b101_101_101_101; load = 1'b1; end
      if (e == 16) load = 1'b0;
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp_num;
    logic       blink_on;
    int         p;
    do_reset();
    blink_mask = 4'b0010;
    for (int e = 1; e <= 111; e++) begin
      @(negedge clk);
      p = (e / 4) % 4;
`ifdef DISPLAY_SCANNER_BLINK_EN
      blink_on = (p == 1) && (((e / 16) / 2) % 2 == 1);
`else
      blink_on = 1'b0;
`endif
      exp_num = (e < 16 || blink_on) ? 3'd4 : 3'd0;
      n_cmp++; if (num !== exp_num) begin n_bad++; $display("FAIL blink_num e=%0d pos=%0d got %0d exp %0d", e, p, num, exp_num); end
      if (e == 1) begin codes_in = 12'h000; load = 1'b1; end
      if (e == 2) load = 1'b0;
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    load       = 1'b0;
    codes_in   = 12'h000;
    blink_mask = 4'b0000;
    test_reset();
    test_scan();
    test_deferred();
    test_overwrite();
    test_collision();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
